// File: rtl/fpmult_execute_module.sv
// rtl/fpmult_execute_module.sv - execute stage of the single-precision FP multiplier: pipelined 24x24 significand product
//
// Purpose:
//   Multiplies two 24-bit unsigned significands (hidden bit included) and returns
//   the exact 48-bit product. The multiply is split into two partial products
//   sized for 25x18 DSP slices so each maps onto one hard multiplier, and the
//   stage is fully pipelined (one operand pair per clock, no stalls).
//
// Ports:
//   clk  in   1   rising-edge clock
//   rst  in   1   asynchronous reset, active-low; clears every pipeline register
//   Ma   in   24  significand A
//   Mb   in   24  significand B
//   Mp   out  48  registered product Ma*Mb, three registers after the inputs
//
// Pipeline:
//   S1  capture Ma, Mb
//   S2  PP_lo = Ma * Mb[16:0], PP_hi = Ma * Mb[23:17]
//   S3  Mp = PP_lo + (PP_hi << 17)

module fpmult_execute_module (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] Ma,
    input  logic [23:0] Mb,
    output logic [47:0] Mp
);

    // S1: operand registers
    logic [23:0] ma_q;
    logic [23:0] mb_q;

    // S2: partial-product registers
    logic [40:0] pp_lo_q;
    logic [30:0] pp_hi_q;

    // Partial products; operands are zero-extended to the product width so the
    // multiply is evaluated unsigned at full precision.
    logic [40:0] pp_lo;
    logic [30:0] pp_hi;
    logic [47:0] sum;

    always_comb begin
        pp_lo = {17'd0, ma_q} * {24'd0, mb_q[16:0]};
        pp_hi = {7'd0, ma_q} * {24'd0, mb_q[23:17]};
        // Recombine: the high partial product carries weight 2^17. The true
        // maximum (0xFFFFFE000001) fits in 48 bits, so no carry is lost.
        sum   = {7'd0, pp_lo_q} + {pp_hi_q, 17'd0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_q    <= '0;
            mb_q    <= '0;
            pp_lo_q <= '0;
            pp_hi_q <= '0;
            Mp      <= '0;
        end else begin
            ma_q    <= Ma;
            mb_q    <= Mb;
            pp_lo_q <= pp_lo;
            pp_hi_q <= pp_hi;
            Mp      <= sum;
        end
    end

endmodule

// File: tb/tb_fpmult_execute_module.sv
// tb/tb_fpmult_execute_module.sv - scoreboard bench for fpmult_execute_module

module tb_fpmult_execute_module;

    logic        clk;
    logic        rst;
    logic [23:0] Ma;
    logic [23:0] Mb;
    logic [47:0] Mp;

    fpmult_execute_module dut (
        .clk (clk),
        .rst (rst),
        .Ma  (Ma),
        .Mb  (Mb),
        .Mp  (Mp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] exp;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;

    always @(posedge clk) cyc++;

    // Reference: plain 64-bit unsigned arithmetic, truncated to the 48-bit result.
    function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[47:0];
    endfunction

    // Called at a negedge: present operands, queue the expected product for the
    // negedge after the third rising edge that follows, then advance one cycle.
    task automatic drive(input logic [23:0] a, input logic [23:0] b,
                         input logic [47:0] exp, input string name);
        exp_t e;
        Ma = a;
        Mb = b;
        e.exp  = exp;
        e.due  = cyc + 3;
        e.name = name;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Called at a negedge with rst low: release reset and expect the flushed
    // zeros for the two cycles before the first new operand pair emerges.
    task automatic release_reset();
        exp_t e;
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            e.exp  = 48'd0;
            e.due  = cyc + k;
            e.name = "post_reset_zero";
            q.push_back(e);
        end
    endtask

    // Monitor: samples 1 ns after each falling edge, checks every due entry.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                tests++;
                if (Mp !== 48'd0) begin
                    failed++;
                    $display("FAIL in_reset: Mp=%h required=%h", Mp, 48'd0);
                end
            end
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                tests++;
                if (e.due < cyc) begin
                    failed++;
                    $display("FAIL %s: missed slot due=%0d now=%0d", e.name, e.due, cyc);
                end else if (Mp !== e.exp) begin
                    failed++;
                    $display("FAIL %s: Mp=%h required=%h", e.name, Mp, e.exp);
                end
            end
        end
    end

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        int          wait_cycles;

        // Reset with zero operands.
        rst = 1'b0;
        Ma  = 24'd0;
        Mb  = 24'd0;
        repeat (4) @(negedge clk);
        release_reset();
        for (int i = 0; i < 3; i++) drive(24'd0, 24'd0, 48'h000000000000, "zero_ops");

        // Unit significands.
        drive(24'h800000, 24'h800000, 48'h400000000000, "unit");

        // Back-to-back stream.
        drive(24'hC00000, 24'hA00000, 48'h780000000000, "stream0");
        drive(24'h900000, 24'h980000, 48'h558000000000, "stream1");
        drive(24'hCF0700, 24'h800000, 48'h678380000000, "stream2");
        drive(24'hC00000, 24'hC00000, 48'h900000000000, "stream3");

        // Boundaries across the 17-bit split.
        drive(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max_max");
        drive(24'hFFFFFF, 24'h01FFFF, 48'h01FFFEFE0001, "max_lo_only");
        drive(24'hFFFFFF, 24'hFE0000, 48'hFDFFFF020000, "max_hi_only");
        drive(24'h000000, 24'hFFFFFF, 48'h000000000000, "zero_max");
        drive(24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, "max_one");

        // Reset mid-stream with three distinct products in flight
        // (not queued: none of them may ever be observed).
        Ma = 24'h123456; Mb = 24'h654321;
        @(negedge clk);
        Ma = 24'hABCDEF; Mb = 24'hFEDCBA;
        @(negedge clk);
        Ma = 24'h777777; Mb = 24'h999999;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (Mp !== 48'd0) begin
            failed++;
            $display("FAIL async_reset: Mp=%h required=%h", Mp, 48'd0);
        end
        q.delete();
        repeat (3) begin
            @(negedge clk);
            Ma = 24'($urandom);
            Mb = 24'($urandom);
        end
        @(negedge clk);
        release_reset();
        drive(24'hC00000, 24'hC00000, 48'h900000000000, "after_reset");

        // Random regression.
        for (int i = 0; i < 10000; i++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            if (i % 97 == 0) a = 24'hFFFFFF;
            if (i % 89 == 0) b = 24'h800000 | 24'($urandom_range(0, 255));
            drive(a, b, ref_mul(a, b), "random");
        end

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        #2;
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d entries left required=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
